// File: rtl/score_round_ctrl.sv
// rtl/score_round_ctrl.sv - session controller with round-robin arbitration over a shared score-update path
module score_round_ctrl #(
    parameter int NPLAYER  = 4,
    parameter int MAXSCORE = 31,
    parameter int NSAMPLE  = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CFG_WE,
    input  logic [7:0]           CFG_LOW,
    input  logic [7:0]           CFG_HIGH,
    input  logic                 START,
    input  logic [NPLAYER-1:0]   REQ,
    input  logic [8*NPLAYER-1:0] DATAi,
    output logic [NPLAYER-1:0]   GNTo,
    output logic [8*NPLAYER-1:0] SCOREo,
    output logic                 BUSYo,
    output logic                 DONEo,
    output logic [1:0]           WINNERo,
    output logic [6:0]           COUNTo
);

    localparam logic [7:0] MAX8 = 8'(MAXSCORE);
    localparam logic [6:0] NS7  = 7'(NSAMPLE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_low;
    logic [7:0]  r_high;
    logic [7:0]  r_score [NPLAYER];
    logic [6:0]  r_count;
    logic [1:0]  r_ptr;
    logic [1:0]  r_winner;

    logic        w_hit;
    logic [1:0]  w_gidx;
    logic [1:0]  w_idx;
    logic [7:0]  w_d;
    logic [7:0]  w_s;
    logic [7:0]  w_new;
    logic [6:0]  w_new_count;
    logic [1:0]  w_best;
    logic [7:0]  w_best_val;
    logic [7:0]  w_val;

    // Rotating priority search starting at r_ptr; the first requester found wins.
    always_comb begin
        w_hit  = 1'b0;
        w_gidx = 2'd0;
        w_idx  = 2'd0;
        if (r_state == S_RUN) begin
            for (int k = 0; k < NPLAYER; k++) begin
                w_idx = r_ptr + 2'(k);
                if (!w_hit && REQ[w_idx]) begin
                    w_hit  = 1'b1;
                    w_gidx = w_idx;
                end
            end
        end
        GNTo = w_hit ? (NPLAYER'(1) << w_gidx) : '0;
    end

    always_comb begin
        w_d = DATAi[8*w_gidx +: 8];
        w_s = r_score[w_gidx];
        if (w_d >= r_high)
            w_new = (w_s >= MAX8 - 8'd1) ? MAX8 : w_s + 8'd2;
        else if ((w_d > r_low) && (w_d < r_high))
            w_new = (w_s >= MAX8) ? MAX8 : w_s + 8'd1;
        else
            w_new = (w_s != 8'd0) ? w_s - 8'd1 : 8'd0;
        w_new_count = r_count + 7'd1;
    end

    // Leader including this edge's update; strict '>' keeps ties on the lowest index.
    always_comb begin
        w_best     = 2'd0;
        w_best_val = (w_gidx == 2'd0) ? w_new : r_score[0];
        w_val      = 8'd0;
        for (int i = 1; i < NPLAYER; i++) begin
            w_val = (2'(i) == w_gidx) ? w_new : r_score[i];
            if (w_val > w_best_val) begin
                w_best_val = w_val;
                w_best     = 2'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NPLAYER; i++)
            SCOREo[8*i +: 8] = r_score[i];
    end

    assign BUSYo   = (r_state == S_RUN);
    assign DONEo   = (r_state == S_DONE);
    assign WINNERo = r_winner;
    assign COUNTo  = r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_low    <= 8'd0;
            r_high   <= 8'd0;
            r_count  <= 7'd0;
            r_ptr    <= 2'd0;
            r_winner <= 2'd0;
            for (int i = 0; i < NPLAYER; i++)
                r_score[i] <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_IDLE && CFG_WE) begin
                        r_low  <= CFG_LOW;
                        r_high <= CFG_HIGH;
                    end
                    if (START) begin
                        r_state <= S_RUN;
                        r_count <= 7'd0;
                        r_ptr   <= 2'd0;
                        for (int i = 0; i < NPLAYER; i++)
                            r_score[i] <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (w_hit) begin
                        r_score[w_gidx] <= w_new;
                        r_count         <= w_new_count;
                        r_ptr           <= w_gidx + 2'd1;
                        if (w_new == MAX8) begin
                            r_state  <= S_DONE;
                            r_winner <= w_gidx;
                        end else if (w_new_count == NS7) begin
                            r_state  <= S_DONE;
                            r_winner <= w_best;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_round_ctrl.sv
// tb/tb_score_round_ctrl.sv - self-checking bench for score_round_ctrl
module tb_score_round_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CFG_WE = 1'b0;
    logic [7:0]  CFG_LOW = 8'd0;
    logic [7:0]  CFG_HIGH = 8'd0;
    logic        START = 1'b0;
    logic        START2 = 1'b0;
    logic [3:0]  REQ = 4'd0;
    logic [31:0] DATAi = 32'd0;

    logic [3:0]  GNTo, GNT2;
    logic [31:0] SCOREo, SCORE2;
    logic        BUSYo, BUSY2, DONEo, DONE2;
    logic [1:0]  WINNERo, WIN2;
    logic [6:0]  COUNTo, COUNT2;

    int total = 0;
    int bad = 0;

    score_round_ctrl #(.NPLAYER(4), .MAXSCORE(31), .NSAMPLE(64)) u_dut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_LOW(CFG_LOW), .CFG_HIGH(CFG_HIGH),
        .START(START), .REQ(REQ), .DATAi(DATAi), .GNTo(GNTo), .SCOREo(SCOREo),
        .BUSYo(BUSYo), .DONEo(DONEo), .WINNERo(WINNERo), .COUNTo(COUNTo)
    );

    score_round_ctrl #(.NPLAYER(4), .MAXSCORE(31), .NSAMPLE(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_LOW(CFG_LOW), .CFG_HIGH(CFG_HIGH),
        .START(START2), .REQ(REQ), .DATAi(DATAi), .GNTo(GNT2), .SCOREo(SCORE2),
        .BUSYo(BUSY2), .DONEo(DONE2), .WINNERo(WIN2), .COUNTo(COUNT2)
    );

    always #5 CLK = ~CLK;

    int m_low, m_high, m_count, m_ptr, m_win;
    int m_sc[4];
    bit m_busy, m_done;

    function automatic int m_grant();
        if (!m_busy) return -1;
        for (int k = 0; k < 4; k++)
            if (REQ[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    always @(posedge CLK or posedge RST) begin : model
        int g, d, s, best;
        if (RST) begin
            m_low = 0; m_high = 0; m_count = 0; m_ptr = 0; m_win = 0;
            m_busy = 0; m_done = 0;
            for (int i = 0; i < 4; i++) m_sc[i] = 0;
        end else begin
            g = m_grant();
            if (!m_busy) begin
                if (!m_done && CFG_WE) begin
                    m_low = CFG_LOW; m_high = CFG_HIGH;
                end
                if (START) begin
                    m_busy = 1; m_done = 0; m_count = 0; m_ptr = 0;
                    for (int i = 0; i < 4; i++) m_sc[i] = 0;
                end
            end else if (g >= 0) begin
                d = int'(DATAi[8*g +: 8]);
                s = m_sc[g];
                if (d >= m_high)                  s = (s + 2 > 31) ? 31 : s + 2;
                else if (d > m_low && d < m_high) s = (s + 1 > 31) ? 31 : s + 1;
                else if (s > 0)                   s = s - 1;
                m_sc[g] = s;
                m_count = m_count + 1;
                m_ptr = (g + 1) % 4;
                if (s == 31) begin
                    m_busy = 0; m_done = 1; m_win = g;
                end else if (m_count == 64) begin
                    best = 0;
                    for (int i = 1; i < 4; i++) if (m_sc[i] > m_sc[best]) best = i;
                    m_busy = 0; m_done = 1; m_win = best;
                end
            end
        end
    end

    always @(negedge CLK) begin : compare
        int eg;
        logic [3:0]  eg_v;
        logic [31:0] es;
        bit ok;
        eg = m_grant();
        eg_v = (eg < 0) ? 4'd0 : 4'(1 << eg);
        es = {m_sc[3][7:0], m_sc[2][7:0], m_sc[1][7:0], m_sc[0][7:0]};
        ok = (GNTo == eg_v) && (SCOREo == es) && (COUNTo == 7'(m_count)) &&
             (BUSYo == m_busy) && (DONEo == m_done) && (!m_done || WINNERo == 2'(m_win));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL model_cycle t=%0t gnt=%b/%b score=%h/%h cnt=%0d/%0d busy=%b/%b done=%b/%b win=%0d/%0d",
                     $time, GNTo, eg_v, SCOREo, es, COUNTo, m_count, BUSYo, m_busy, DONEo, m_done, WINNERo, m_win);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_session();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic configure(input logic [7:0] lo, input logic [7:0] hi);
        CFG_LOW = lo; CFG_HIGH = hi; CFG_WE = 1'b1;
        tick();
        CFG_WE = 1'b0;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        #1;
        RST = 1'b0;
    endtask

    int t3_d[6] = '{10, 0, 15, 10, 20, 19};
    int t3_s[6] = '{0, 0, 1, 0, 2, 3};

    initial begin
        repeat (2) tick();
        RST = 1'b0;
        chk("rst_score", SCOREo, 32'h0);
        chk("rst_count", {25'd0, COUNTo}, 32'd0);
        chk("rst_flags", {29'd0, GNTo == 4'd0, BUSYo, DONEo}, 32'b100);
        chk("rst_winner", {30'd0, WINNERo}, 32'd0);

        configure(8'd10, 8'd20);
        start_session();
        chk("t1_busy", {31'd0, BUSYo}, 32'd1);
        REQ = 4'hF; DATAi = 32'h19191919;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_gnt", {28'd0, GNTo}, 32'(1 << i));
            tick();
        end
        chk("t1_score", SCOREo, 32'h02020202);
        chk("t1_count", {25'd0, COUNTo}, 32'd4);
        REQ = 4'd0;

        pulse_reset();
        configure(8'd10, 8'd20);
        start_session();
        REQ = 4'b0100; DATAi = 32'h00140000;
        repeat (15) tick();
        chk("t2_score15", SCOREo, 32'h001E0000);
        tick();
        chk("t2_score16", SCOREo, 32'h001F0000);
        chk("t2_done", {29'd0, DONEo, BUSYo, GNTo == 4'd0}, 32'b101);
        chk("t2_winner", {30'd0, WINNERo}, 32'd2);

        REQ = 4'b0001; DATAi = 32'd0;
        start_session();
        chk("t3_cleared", SCOREo, 32'h0);
        for (int i = 0; i < 6; i++) begin
            DATAi = 32'(t3_d[i]);
            tick();
            chk("t3_floor_band", SCOREo, 32'(t3_s[i]));
        end

        REQ = 4'd0; CFG_LOW = 8'd50; CFG_WE = 1'b1; START = 1'b1;
        tick();
        CFG_WE = 1'b0; START = 1'b0;
        chk("t5_busy", {31'd0, BUSYo}, 32'd1);
        chk("t5_count", {25'd0, COUNTo}, 32'd6);
        REQ = 4'b0001; DATAi = 32'd15;
        tick();
        chk("t5_low_kept", SCOREo, 32'd4);
        REQ = 4'd0;

        pulse_reset();
        configure(8'd10, 8'd20);
        start_session();
        REQ = 4'b1010; DATAi = 32'h05000F00;
        for (int n = 0; n < 100 && !DONEo; n++) tick();
        chk("t4_done", {31'd0, DONEo}, 32'd1);
        chk("t4_count", {25'd0, COUNTo}, 32'd61);
        chk("t4_winner", {30'd0, WINNERo}, 32'd1);
        chk("t4_score", SCOREo, 32'h00001F00);

        REQ = 4'hF; DATAi = 32'h19191919;
        START2 = 1'b1;
        tick();
        START2 = 1'b0;
        repeat (7) tick();
        chk("b8_busy7", {30'd0, BUSY2, DONE2}, 32'b10);
        tick();
        chk("b8_done", {30'd0, BUSY2, DONE2}, 32'b01);
        chk("b8_tie_winner", {30'd0, WIN2}, 32'd0);
        chk("b8_score", SCORE2, 32'h04040404);
        chk("b8_count", {25'd0, COUNT2}, 32'd8);

        REQ = 4'b0110; DATAi = 32'h00190000;
        START2 = 1'b1;
        tick();
        START2 = 1'b0;
        repeat (8) tick();
        chk("b8_lead_winner", {30'd0, WIN2}, 32'd2);
        chk("b8_lead_score", SCORE2, 32'h00080000);

        REQ = 4'hF; DATAi = 32'h19191919;
        start_session();
        repeat (3) tick();
        chk("t6_pre", SCOREo, 32'h00020202);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_async_score", SCOREo, 32'h0);
        chk("t6_async_flags", {25'd0, COUNTo}, 32'd0);
        chk("t6_async_state", {29'd0, BUSYo, DONEo, GNTo == 4'd0}, 32'b001);
        tick();
        RST = 1'b0;
        REQ = 4'b0001; DATAi = 32'd0;
        start_session();
        repeat (3) tick();
        chk("t6_zero_thr", SCOREo, 32'd6);
        chk("t6_count", {25'd0, COUNTo}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
